mem_bus_arbiter: RTL and testbench

Sequential arbiter that shares the single platform memory bus between two masters: A (debug probe) and B (CPU data port). It replaces a purely combinational master select with a request/grant/acknowledge handshake. Master A has fixed priority, and a starvation guard guarantees B forward progress. Its slave side drives the existing slave-bus address decoder.

---
 rtl/mem_bus_arbiter_pkg.sv | 18 +
 rtl/mem_bus_arbiter_prio_guard.sv | 39 +++
 rtl/mem_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the two-master memory bus arbiter: FSM state, bus owner
// encoding and the default starvation limit.
package mem_bus_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWNER_B = 1'b0,
    OWNER_A = 1'b1
  } arb_owner_t;

  localparam int ARB_MAX_A_STREAK_DEFAULT = 4;
  localparam int ARB_STREAK_CNT_W         = 3;

endpackage

// File: rtl/mem_bus_arbiter_prio_guard.sv
// Fixed-priority grant decision (A over B) with a saturating starvation
// counter that forces a B grant after MAX_A_STREAK back-to-back A grants.
module arb_fixed_prio_guard
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_A_STREAK = ARB_MAX_A_STREAK_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,
  input  logic a_req,
  input  logic b_req,
  output logic grant_a,
  output logic grant_b
);

  localparam logic [ARB_STREAK_CNT_W-1:0] STREAK_LIM = ARB_STREAK_CNT_W'(MAX_A_STREAK);

  if (MAX_A_STREAK < 1 || MAX_A_STREAK > 7) begin : g_bad_streak
    $error("MAX_A_STREAK must fit the 3-bit starvation counter");
  end

  logic [ARB_STREAK_CNT_W-1:0] starve_cnt;

  assign grant_a = arb_en && a_req && (!b_req || (starve_cnt < STREAK_LIM));
  assign grant_b = arb_en && b_req && !grant_a;

  // Only A grants that actually made B wait count toward the streak.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant_a && b_req) begin
      if (starve_cnt < STREAK_LIM) starve_cnt <= starve_cnt + 1'b1;
    end else if (grant_a || grant_b) begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master memory bus arbiter with request/grant/ack handshake toward the
// slave decoder. Define ARB_TIMEOUT_EN to add the slave response timeout.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 30,
  parameter int MAX_A_STREAK   = ARB_MAX_A_STREAK_DEFAULT,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_we,
  input  logic              a_mem_read,
  input  logic [3:0]        a_mask_byte,
  input  logic [31:0]       a_wdata,
  output logic              a_ack,
  output logic [31:0]       a_rdata,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_we,
  input  logic              b_mem_read,
  input  logic [3:0]        b_mask_byte,
  input  logic [31:0]       b_wdata,
  output logic              b_ack,
  output logic [31:0]       b_rdata,
  output logic              s_valid,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_we,
  output logic              s_mem_read,
  output logic [3:0]        s_mask_byte,
  output logic [31:0]       s_wdata,
  input  logic              s_ready,
  input  logic [31:0]       s_rdata,
  output logic              owner,
  output logic              err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 8-bit timeout counter");
  end

  arb_state_t state;
  arb_owner_t owner_q;
  logic       grant_a;
  logic       grant_b;
  logic       timeout_hit;

  assign owner = owner_q;

  arb_fixed_prio_guard #(
    .MAX_A_STREAK(MAX_A_STREAK)
  ) u_guard (
    .clk    (clk),
    .rst_n  (rst_n),
    .arb_en (state == IDLE),
    .a_req  (a_req),
    .b_req  (b_req),
    .grant_a(grant_a),
    .grant_b(grant_b)
  );

`ifdef ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  assign timeout_hit = !s_ready && (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // NOTE: every register here uses <= so all of them see the same pre-edge
  // values; blocking writes would let later statements observe new state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner_q     <= OWNER_B;
      s_valid     <= 1'b0;
      s_addr      <= '0;
      s_we        <= 1'b0;
      s_mem_read  <= 1'b0;
      s_mask_byte <= '0;
      s_wdata     <= '0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt     <= '0;
      err         <= 1'b0;
`endif
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (grant_a || grant_b) begin
            s_addr      <= grant_a ? a_addr      : b_addr;
            s_we        <= grant_a ? a_we        : b_we;
            s_mem_read  <= grant_a ? a_mem_read  : b_mem_read;
            s_mask_byte <= grant_a ? a_mask_byte : b_mask_byte;
            s_wdata     <= grant_a ? a_wdata     : b_wdata;
            owner_q     <= grant_a ? OWNER_A     : OWNER_B;
            s_valid     <= 1'b1;
            state       <= BUSY;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
          end
        end
        BUSY: begin
          // s_* are left untouched here, which keeps them stable until done.
          if (s_ready || timeout_hit) begin
            if (owner_q == OWNER_A) begin
              a_rdata <= s_ready ? s_rdata : 32'h0;
              a_ack   <= 1'b1;
            end else begin
              b_rdata <= s_ready ? s_rdata : 32'h0;
              b_ack   <= 1'b1;
            end
            s_valid <= 1'b0;
            state   <= IDLE;
`ifdef ARB_TIMEOUT_EN
            err     <= timeout_hit;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed stimulus pushes expected
// grants/acks; a negedge monitor pops and compares them as the DUT responds.
module tb_mem_bus_arbiter;

  localparam int ADDR_W = 30;

  typedef struct {
    logic              owner;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic              rd;
    logic [3:0]        mask;
    logic [31:0]       wdata;
    int                busy_len;  // 0 = do not check length
  } grant_t;

  typedef struct {
    logic        is_a;
    logic [31:0] rdata;
    logic        err;
  } ack_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              a_req = 1'b0, b_req = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
  logic              a_we = 1'b0, b_we = 1'b0;
  logic              a_mem_read = 1'b0, b_mem_read = 1'b0;
  logic [3:0]        a_mask_byte = '0, b_mask_byte = '0;
  logic [31:0]       a_wdata = '0, b_wdata = '0;
  logic              a_ack, b_ack, err, owner, s_valid;
  logic [31:0]       a_rdata, b_rdata, s_wdata;
  logic [ADDR_W-1:0] s_addr;
  logic              s_we, s_mem_read;
  logic [3:0]        s_mask_byte;
  logic              s_ready = 1'b0;
  logic [31:0]       s_rdata = 32'h0BAD0BAD;

  grant_t q_grant[$];
  ack_t   q_ack[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     slave_delay = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W(ADDR_W), .MAX_A_STREAK(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_we(a_we), .a_mem_read(a_mem_read),
    .a_mask_byte(a_mask_byte), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_we(b_we), .b_mem_read(b_mem_read),
    .b_mask_byte(b_mask_byte), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_we(s_we), .s_mem_read(s_mem_read),
    .s_mask_byte(s_mask_byte), .s_wdata(s_wdata), .s_ready(s_ready), .s_rdata(s_rdata),
    .owner(owner), .err(err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] slave_word(input logic [ADDR_W-1:0] addr);
    return (addr == 30'h10) ? 32'hDEADBEEF : {8'hA5, addr[23:0]};
  endfunction

  task automatic expect_txn(input logic is_a, input logic [ADDR_W-1:0] addr, input logic we,
                            input logic [3:0] mask, input logic [31:0] wdata, input int busy_len,
                            input logic acked, input logic [31:0] rdata, input logic e);
    q_grant.push_back('{is_a, addr, we, !we, mask, wdata, busy_len});
    if (acked) q_ack.push_back('{is_a, rdata, e});
  endtask

  // Slave: answers after slave_delay wait cycles; garbage data when not ready.
  int s_wait = 0;
  always @(negedge clk) begin
    if (!rst_n || !s_valid) begin
      s_ready = 1'b0;
      s_wait  = 0;
      s_rdata = 32'h0BAD0BAD;
    end else if (s_wait >= slave_delay) begin
      s_ready = 1'b1;
      s_rdata = slave_word(s_addr);
    end else begin
      s_ready = 1'b0;
      s_wait++;
    end
  end

  // Monitor / scoreboard.
  logic        prev_valid = 1'b0;
  int          valid_cycles = 0;
  int          cur_busy = 0;
  logic [35:0] snap_ctl;
  logic [31:0] snap_wdata;
  logic [31:0] last_a = '0, last_b = '0;
  grant_t      mg;
  ack_t        ma;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      last_a     = '0;
      last_b     = '0;
    end else begin
      if (s_valid && !prev_valid) begin
        if (q_grant.size() == 0) begin
          check("unexpected_grant", {63'b0, s_valid}, 64'd0);
        end else begin
          mg = q_grant.pop_front();
          check("grant_owner", owner, mg.owner);
          check("grant_addr", s_addr, mg.addr);
          check("grant_we", s_we, mg.we);
          check("grant_rd", s_mem_read, mg.rd);
          check("grant_mask", s_mask_byte, mg.mask);
          check("grant_wdata", s_wdata, mg.wdata);
          cur_busy = mg.busy_len;
        end
        snap_ctl     = {s_addr, s_we, s_mem_read, s_mask_byte};
        snap_wdata   = s_wdata;
        valid_cycles = 0;
      end
      if (s_valid) begin
        valid_cycles++;
        if (prev_valid) begin
          check("hold_ctl", {s_addr, s_we, s_mem_read, s_mask_byte}, snap_ctl);
          check("hold_wdata", s_wdata, snap_wdata);
        end
      end
      if (!s_valid && prev_valid && cur_busy > 0) check("busy_cycles", valid_cycles, cur_busy);
      if (a_ack || b_ack) begin
        if (q_ack.size() == 0) begin
          check("unexpected_ack", {a_ack, b_ack}, 64'd0);
        end else begin
          ma = q_ack.pop_front();
          check("ack_which", {a_ack, b_ack}, {ma.is_a, !ma.is_a});
          check("ack_err", err, ma.err);
          if (ma.is_a) begin
            check("a_rdata", a_rdata, ma.rdata);
            check("b_rdata_hold", b_rdata, last_b);
            last_a = ma.rdata;
          end else begin
            check("b_rdata", b_rdata, ma.rdata);
            check("a_rdata_hold", a_rdata, last_a);
            last_b = ma.rdata;
          end
        end
      end else if (err) begin
        check("err_without_ack", err, 1'b0);
      end
      prev_valid = s_valid;
    end
  end

  // Masters keep requesting until they have seen the requested number of acks.
  task automatic run_masters(input int na, input int nb, input int budget);
    int a_left = na;
    int b_left = nb;
    int cyc = 0;
    a_req = (na > 0);
    b_req = (nb > 0);
    while ((a_left > 0 || b_left > 0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (a_ack && a_left > 0) begin
        a_left--;
        a_addr = a_addr + 1'b1;
        if (a_left == 0) a_req = 1'b0;
      end
      if (b_ack && b_left > 0) begin
        b_left--;
        b_addr = b_addr + 1'b1;
        if (b_left == 0) b_req = 1'b0;
      end
    end
    check("masters_done", a_left + b_left, 64'd0);
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    string pat;
    int    ai, bi;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_s_valid", s_valid, 1'b0);
    check("rst_a_ack", a_ack, 1'b0);
    check("rst_b_ack", b_ack, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_owner", owner, 1'b0);
    check("rst_s_bus", {s_addr, s_we, s_mem_read, s_mask_byte}, 64'd0);
    check("rst_s_wdata", s_wdata, 64'd0);
    check("rst_rdata", {a_rdata, b_rdata}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single read from B.
    b_addr = 30'h10; b_we = 1'b0; b_mem_read = 1'b1; b_mask_byte = 4'hF; b_wdata = '0;
    expect_txn(1'b0, 30'h10, 1'b0, 4'hF, 32'h0, 1, 1'b1, 32'hDEADBEEF, 1'b0);
    b_req = 1'b1;
    @(negedge clk);
    check("t1_valid_cycle1", s_valid, 1'b1);
    @(negedge clk);
    check("t1_ack_cycle2", b_ack, 1'b1);
    b_req = 1'b0;
    @(negedge clk);

    // Simultaneous requests: A first, B right behind it.
    a_addr = 30'h20; a_we = 1'b1; a_mem_read = 1'b0; a_mask_byte = 4'h3; a_wdata = 32'h11223344;
    b_addr = 30'h30; b_we = 1'b0; b_mem_read = 1'b1; b_mask_byte = 4'hF; b_wdata = '0;
    expect_txn(1'b1, 30'h20, 1'b1, 4'h3, 32'h11223344, 1, 1'b1, 32'hA5000020, 1'b0);
    expect_txn(1'b0, 30'h30, 1'b0, 4'hF, 32'h0, 1, 1'b1, 32'hA5000030, 1'b0);
    a_req = 1'b1; b_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t2_a_ack", a_ack, 1'b1);
    a_req = 1'b0;
    @(negedge clk);
    check("t2_b_valid_next", s_valid, 1'b1);
    @(negedge clk);
    check("t2_b_ack", b_ack, 1'b1);
    b_req = 1'b0;
    @(negedge clk);

    // Starvation guard: A held for 9 accesses, B for 2.
    a_addr = 30'h100; a_we = 1'b0; a_mem_read = 1'b1; a_mask_byte = 4'hF; a_wdata = 32'h0;
    b_addr = 30'h200;
    pat = "AAAABAAAABA";
    ai = 0; bi = 0;
    for (int i = 0; i < pat.len(); i++) begin
      if (pat[i] == "A") begin
        expect_txn(1'b1, 30'h100 + ai, 1'b0, 4'hF, 32'h0, 1, 1'b1, {8'hA5, 24'h000100 + 24'(ai)}, 1'b0);
        ai++;
      end else begin
        expect_txn(1'b0, 30'h200 + bi, 1'b0, 4'hF, 32'h0, 1, 1'b1, {8'hA5, 24'h000200 + 24'(bi)}, 1'b0);
        bi++;
      end
    end
    run_masters(9, 2, 200);
    @(negedge clk);

    // Slow slave: 5 wait cycles, 6 BUSY cycles with stable s_* bus.
    slave_delay = 5;
    a_addr = 30'h55; a_we = 1'b1; a_mem_read = 1'b0; a_mask_byte = 4'h5; a_wdata = 32'hCAFEF00D;
    expect_txn(1'b1, 30'h55, 1'b1, 4'h5, 32'hCAFEF00D, 6, 1'b1, 32'hA5000055, 1'b0);
    run_masters(1, 0, 50);
    slave_delay = 0;
    @(negedge clk);

    // Reset during BUSY: outputs clear at once and no ack ever appears.
    slave_delay = 20;
    b_addr = 30'h40; b_we = 1'b0; b_mem_read = 1'b1; b_mask_byte = 4'hF;
    expect_txn(1'b0, 30'h40, 1'b0, 4'hF, 32'h0, 0, 1'b0, 32'h0, 1'b0);
    b_req = 1'b1;
    for (int i = 0; i < 10 && !s_valid; i++) @(negedge clk);
    check("t5_in_busy", s_valid, 1'b1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_s_valid", s_valid, 1'b0);
    check("t5_rst_owner_addr", {owner, s_addr}, 64'd0);
    check("t5_rst_rdata", {a_rdata, b_rdata}, 64'd0);
    b_req = 1'b0;
    slave_delay = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    a_addr = 30'h66; a_we = 1'b0; a_mem_read = 1'b1; a_mask_byte = 4'hC; a_wdata = 32'h0;
    expect_txn(1'b1, 30'h66, 1'b0, 4'hC, 32'h0, 1, 1'b1, 32'hA5000066, 1'b0);
    a_req = 1'b1;
    @(negedge clk);
    check("t5_idle_after_rst", s_valid, 1'b1);
    @(negedge clk);
    check("t5_a_ack", a_ack, 1'b1);
    a_req = 1'b0;
    @(negedge clk);

`ifdef ARB_TIMEOUT_EN
    // Slave never answers: timeout ack with err and zero data.
    slave_delay = 1000;
    b_addr = 30'h77; b_we = 1'b0; b_mem_read = 1'b1; b_mask_byte = 4'hF;
    expect_txn(1'b0, 30'h77, 1'b0, 4'hF, 32'h0, 8, 1'b1, 32'h0, 1'b1);
    run_masters(0, 1, 50);
    slave_delay = 0;
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    check("grant_queue_drained", q_grant.size(), 64'd0);
    check("ack_queue_drained", q_ack.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
